button_conditioner: RTL and testbench

- Front-end stage that sits directly upstream of the engine top.
- Takes raw board push-buttons (up, down, left, right, power) and conditions them before they reach the engine's direction and power inputs. Conditioning is synchronise, debounce, then edge and long-press detection.
- Also owns the power latch: a short press of the power button turns the car on; a long press turns it off.
- Runs on the divided clock feeding the engine FSMs.

---
 rtl/button_conditioner.sv | 125 ++++++++++++
 tb/tb_button_conditioner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchroniser, per-bit debounce, edge and
// long-press pulses, plus the power on/off latch driven by the top button.

module button_lane #(
    parameter int DEBOUNCE_CYCLES   = 20,
    parameter int LONG_PRESS_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);
    localparam logic [7:0]  DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] HOLD_MAX = 16'(LONG_PRESS_CYCLES);

    logic        s1_q, s2_q;
    logic [7:0]  db_cnt_q, db_cnt_d;
    logic        level_q, level_d;
    logic [15:0] hold_q, hold_d;
    logic        press_q, release_q, long_q;
    logic        long_d;

    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (s2_q != level_q) begin
            if (db_cnt_q == DB_LAST) level_d = s2_q;
            else                     db_cnt_d = db_cnt_q + 8'd1;
        end
        // Hold count tracks the new level so the press cycle itself counts as 1.
        hold_d = '0;
        if (level_d) hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 16'd1;
        long_d = level_d && (hold_q == HOLD_MAX - 16'd1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            s1_q      <= raw_i;
            s2_q      <= s1_q;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            hold_q    <= hold_d;
            press_q   <= level_d & ~level_q;
            release_q <= ~level_d & level_q;
            long_q    <= long_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
endmodule

module button_conditioner #(
    parameter int N_BTN             = 5,
    parameter int DEBOUNCE_CYCLES   = 20,
    parameter int LONG_PRESS_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic             power_on
);
    localparam int P = N_BTN - 1;

    logic power_q, power_d;
    logic armed_q, armed_d;

    for (genvar k = 0; k < N_BTN; k++) begin : g_lane
        button_lane #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .raw_i    (btn_raw[k]),
            .level_o  (btn_level[k]),
            .press_o  (btn_press[k]),
            .release_o(btn_release[k]),
            .long_o   (btn_long[k])
        );
    end

    // armed remembers whether this press began with the car on; only such a
    // hold may switch it off.
    always_comb begin
        power_d = power_q;
        armed_d = armed_q;
        if (btn_press[P]) begin
            armed_d = power_q;
            if (!power_q) power_d = 1'b1;
        end else if (btn_long[P] && armed_q) begin
            power_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            power_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            power_q <= power_d;
            armed_q <= armed_d;
        end
    end

    assign power_on = power_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed table, corner sequences and random
// stimulus against a window/history based reference model.

module tb_button_conditioner;
    localparam int N  = 5;
    localparam int DB = 4;
    localparam int LP = 10;
    localparam int P  = N - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_long;
    logic         power_on;

    button_conditioner #(
        .N_BTN(N), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_long(btn_long),
        .power_on(power_on)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [N-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_long;
    logic         m_pwr, m_armed;
    logic [N-1:0] win [DB];
    int           hi_cnt [N];

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
        m_pwr = 1'b0; m_armed = 1'b0;
        for (int j = 0; j < DB; j++) win[j] = '0;
        for (int k = 0; k < N; k++) hi_cnt[k] = 0;
    endfunction

    // Level flips once the last DB synchronised samples all disagree with it.
    function automatic void model_edge(logic [N-1:0] raw);
        logic [N-1:0] nl;
        logic         diff;
        for (int j = DB - 1; j > 0; j--) win[j] = win[j-1];
        win[0] = m_s2;
        for (int k = 0; k < N; k++) begin
            diff = 1'b1;
            for (int j = 0; j < DB; j++) if (win[j][k] == m_level[k]) diff = 1'b0;
            nl[k] = diff ? ~m_level[k] : m_level[k];
        end
        if (m_press[P]) begin
            m_armed = m_pwr;
            if (!m_pwr) m_pwr = 1'b1;
        end else if (m_long[P] && m_armed) m_pwr = 1'b0;
        m_press = nl & ~m_level;
        m_rel   = ~nl & m_level;
        for (int k = 0; k < N; k++) begin
            hi_cnt[k] = nl[k] ? hi_cnt[k] + 1 : 0;
            m_long[k] = nl[k] && (hi_cnt[k] == LP);
        end
        m_level = nl;
        m_s2 = m_s1;
        m_s1 = raw;
    endfunction

    task automatic step(input logic [N-1:0] raw);
        btn_raw = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        check("level",   32'(btn_level),   32'(m_level));
        check("press",   32'(btn_press),   32'(m_press));
        check("release", 32'(btn_release), 32'(m_rel));
        check("long",    32'(btn_long),    32'(m_long));
        check("power",   32'(power_on),    32'(m_pwr));
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        model_clear();
        check("async_reset_outs",
              {power_on, btn_long, btn_release, btn_press, btn_level}, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] raw;
        logic         exp_level;
        logic         exp_press;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int c_lvl, c_pr, c_rl, c_lg;
        int i_pr, i_lg, i_pw, i_pr3, i_lg3, i_lv;
        logic [N-1:0] r;

        reset = 1'b0;
        btn_raw = '0;
        model_clear();
        #12;
        check("reset_state",
              {power_on, btn_long, btn_release, btn_press, btn_level}, '0);
        reset = 1'b1;

        // 1: clean press latency on bit 0
        for (int i = 0; i < 8; i++) begin
            tbl[i].raw = 5'b00001;
            tbl[i].exp_level = (i >= 5);
            tbl[i].exp_press = (i == 5);
        end
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].raw);
            check("t1_level0", 32'(btn_level[0]), 32'(tbl[i].exp_level));
            check("t1_press0", 32'(btn_press[0]), 32'(tbl[i].exp_press));
        end
        for (int i = 0; i < 8; i++) step('0);

        // 2: glitch rejection and minimal accepted pulse on bit 1
        for (int w = 3; w <= 4; w++) begin
            c_lvl = 0; c_pr = 0; c_rl = 0;
            for (int i = 0; i < 16; i++) begin
                step((i < w) ? 5'b00010 : 5'b00000);
                c_lvl += int'(btn_level[1]);
                c_pr  += int'(btn_press[1]);
                c_rl  += int'(btn_release[1]);
            end
            check("t2_level_cycles", 32'(c_lvl), (w == 4) ? 32'd4 : 32'd0);
            check("t2_press_cnt",    32'(c_pr),  (w == 4) ? 32'd1 : 32'd0);
            check("t2_release_cnt",  32'(c_rl),  (w == 4) ? 32'd1 : 32'd0);
        end

        // 3: power from off, held 20 cycles
        i_pr = -1; i_lg = -1; i_pw = -1; c_lg = 0;
        for (int i = 0; i < 32; i++) begin
            step((i < 20) ? 5'b10000 : 5'b00000);
            if (btn_press[P] && i_pr < 0) i_pr = i;
            if (btn_long[P]) begin c_lg++; if (i_lg < 0) i_lg = i; end
            if (power_on && i_pw < 0) i_pw = i;
        end
        check("t3_press_at", 32'(i_pr), 32'd5);
        check("t3_power_at", 32'(i_pw), 32'd6);
        check("t3_long_at",  32'(i_lg), 32'd14);
        check("t3_long_cnt", 32'(c_lg), 32'd1);
        check("t3_power_end", 32'(power_on), 32'd1);

        // 4a: car on, held 15 cycles turns it off
        i_lg = -1; i_pw = -1;
        for (int i = 0; i < 28; i++) begin
            step((i < 15) ? 5'b10000 : 5'b00000);
            if (btn_long[P] && i_lg < 0) i_lg = i;
            if (!power_on && i_pw < 0) i_pw = i;
        end
        check("t4_long_at", 32'(i_lg), 32'd14);
        check("t4_off_at",  32'(i_pw), 32'd15);
        // 4b: turn on with a short press, then a 6-cycle press has no effect
        for (int i = 0; i < 20; i++) step((i < 8) ? 5'b10000 : 5'b00000);
        check("t4_on_again", 32'(power_on), 32'd1);
        c_lg = 0; c_lvl = 0;
        for (int i = 0; i < 20; i++) begin
            step((i < 6) ? 5'b10000 : 5'b00000);
            c_lg  += int'(btn_long[P]);
            c_lvl += int'(btn_level[P]);
        end
        check("t4_short_level", 32'(c_lvl), 32'd6);
        check("t4_short_nolong", 32'(c_lg), 32'd0);
        check("t4_short_power", 32'(power_on), 32'd1);

        // 5: reset mid-hold on bit 2
        for (int i = 0; i < 14; i++) step(5'b00100);
        pulse_reset();
        i_lv = -1; i_pr = -1; i_lg = -1;
        for (int i = 0; i < 20; i++) begin
            step(5'b00100);
            if (btn_level[2] && i_lv < 0) i_lv = i;
            if (btn_press[2] && i_pr < 0) i_pr = i;
            if (btn_long[2] && i_lg < 0) i_lg = i;
        end
        check("t5_level_at", 32'(i_lv), 32'd5);
        check("t5_press_at", 32'(i_pr), 32'd5);
        check("t5_long_at",  32'(i_lg), 32'd14);
        for (int i = 0; i < 10; i++) step('0);

        // 6: simultaneous presses on bits 0 and 3
        i_pr = -1; i_pr3 = -1; i_lg = -1; i_lg3 = -1;
        for (int i = 0; i < 30; i++) begin
            step((i < 18) ? 5'b01001 : 5'b00000);
            if (btn_press[0] && i_pr  < 0) i_pr  = i;
            if (btn_press[3] && i_pr3 < 0) i_pr3 = i;
            if (btn_long[0]  && i_lg  < 0) i_lg  = i;
            if (btn_long[3]  && i_lg3 < 0) i_lg3 = i;
        end
        check("t6_press0_at", 32'(i_pr),  32'd5);
        check("t6_press3_at", 32'(i_pr3), 32'd5);
        check("t6_long0_at",  32'(i_lg),  32'd14);
        check("t6_long3_at",  32'(i_lg3), 32'd14);

        // Random soak: slow toggles give long holds, fast ones give glitches
        r = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, (i % 400 < 100) ? 3 : 23) == 0) r[k] = ~r[k];
            if ($urandom_range(0, 999) == 0) pulse_reset();
            step(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
